snake_core_multi: RTL and testbench
===================================

Name: snake_core_multi

Overview:
- Parametrised next-generation snake engine: grid size, cell size, max length, initial length and growth step per food are all parameters.
- Adds a turn queue with reversal rejection, an optional wrap-around playfield, multi-segment growth and wall-collision detection.
- Adds a game-state FSM: IDLE, RUN, DEAD.
- Sits between the input/tick generator and the renderer/food logic; exports head position, length, packed body buses and a valid mask.

Parameters:
- CELL, 10, cell size in pixels.
- GRID_W, 64, playfield width in cells, including a 1-cell border each side.
- GRID_H, 48, playfield height in cells, including the border.
- MAX_LEN, 33, max segments including head; must be ≤255.
- INIT_LEN, 2, length after init; must satisfy 2 ≤ INIT_LEN ≤ MAX_LEN.
- GROW_STEP, 2, segments added per eat_evt.
- DIRQ_DEPTH, 2, turn-queue depth.
- START_X, 370, head X at init (cell-aligned).
- START_Y, 280, head Y at init (cell-aligned).

Ports:
- clk_pix, in, 1, pixel clock.
- reset, in, 1, reset.
- start, in, 1, pulse: IDLE→RUN, or DEAD→reinit+RUN.
- tick, in, 1, one-cycle move strobe.
- dir_in, in, 2, requested direction: 0=UP, 1=LEFT, 2=DOWN, 3=RIGHT.
- dir_valid, in, 1, dir_in strobe.
- eat_evt, in, 1, one-cycle food pulse.
- wrap_mode, in, 1, 1 = wrap at border, 0 = wall kills; sampled on start.
- state, out, 2, 0=IDLE, 1=RUN, 2=DEAD.
- head_x, out, 10, head X in pixels.
- head_y, out, 9, head Y in pixels.
- length, out, 8, current length.
- move_evt, out, 1, pulse: a move was committed.
- self_hit, out, 1, pulse: self collision.
- wall_hit, out, 1, pulse: wall collision.
- body_bus_x, out, MAX_LEN*10, packed segments, seg0 (head) in the MSBs.
- body_bus_y, out, MAX_LEN*9, packed segments, seg0 (head) in the MSBs.
- body_valid, out, MAX_LEN, bit i = 1 iff i < length.

Behaviour:
- Interface: one clock (clk_pix); reset is asynchronous and active-high. All outputs are registered.
- Reset / init values:
  - state=IDLE, length=INIT_LEN, cur_dir=RIGHT, turn queue empty, pending_grow=0.
  - Segments: seg[i] = (START_X − i·CELL, START_Y) for i < INIT_LEN; seg[i] = seg[INIT_LEN−1] for all higher i.
  - All pulse outputs 0.
- Playfield: XMIN=CELL, XMAX=(GRID_W−2)·CELL; YMIN=CELL, YMAX=(GRID_H−2)·CELL.
- FSM:
  - IDLE: ticks are ignored; on start, latch wrap_mode and go to RUN.
  - RUN: moves on tick; any hit → DEAD.
  - DEAD: frozen; on start, re-init all state (as reset) and go to RUN in the same cycle.
- Turn queue (FIFO, DIRQ_DEPTH entries), active in RUN only:
  - The reference direction is the last queued entry, or cur_dir if the queue is empty.
  - dir_valid is dropped if the queue is full, dir_in equals the reference, or dir_in = reference ^ 2 (reversal).
  - On a RUN tick, a non-empty queue pops into cur_dir before the move is computed.
  - dir_valid in the same cycle as tick is enqueued after the pop and does not affect that tick.
- Move, on a RUN tick:
  - nx/ny = head ± CELL along cur_dir.
  - If the result leaves [MIN, MAX]:
    - wrap=1: the coordinate becomes the opposite bound (620→10, 10→620).
    - wrap=0: wall_hit=1, state→DEAD, no move.
  - grow = (pending_grow > 0) && (length < MAX_LEN).
  - Self-collision is checked against pre-move seg[1..length−2] when not growing (the vacated tail is legal), or seg[1..length−1] when growing.
  - On self-collision: self_hit=1, state→DEAD, no move.
  - Otherwise:
    - Shift seg[i] ← seg[i−1]; seg[0] ← (nx, ny); head_x/head_y updated; move_evt=1.
    - If grow: seg[length] ← old tail, length+1, pending_grow−1.
- Growth counter:
  - eat_evt adds GROW_STEP to pending_grow, saturating at MAX_LEN.
  - eat_evt in the same cycle as a growing tick gives net pending − 1 + GROW_STEP.
  - eat_evt is accepted in RUN only.
  - At length == MAX_LEN, pending_grow is cleared.
- Latency: tick at cycle N → head, buses, length and pulses valid at N+1. Pulses last exactly 1 cycle.
- Reset mid-RUN: immediate asynchronous return to the init values.

Decomposition:
- Package snake_pkg holds:
  - direction localparams DIR_UP/LEFT/DOWN/RIGHT;
  - state encodings ST_IDLE/RUN/DEAD;
  - function is_reverse(a, b).
- Sub-module snake_dir_queue: the turn FIFO, including reversal/duplicate filtering; ports push, dir_in, pop, cur_dir, dir_out.

Test Plan:
- Reset, start, 3 ticks with no dir → head_x=400, head_y=280, seg1=(390,280), length=2, move_evt 3 times.
- One eat_evt, then 2 ticks → length 3 then 4; seg3 equals the pre-tick tail; body_valid=4'b1111 in the MSBs.
- Heading RIGHT: dir LEFT → dropped. UP then LEFT, both before the next tick → tick1 head=(400,270), tick2 head=(390,270).
- wrap=0, head at x=620 heading RIGHT, tick → wall_hit pulse, state=DEAD, head_x stays 620. wrap=1, same setup → head_x=10.
- Length 5 at (400..360, 280), turns UP, LEFT, DOWN → third tick targets (390,280) = seg3 → self_hit, DEAD. Same with length 4 → the target is the tail, so a legal move.
- Grow to MAX_LEN with extra eats → length holds 33 and pending clears. Assert reset mid-RUN → immediate init values. start from DEAD → RUN with length=2.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake engine: directions, game states and the
// reversal test used by the turn queue.
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   // Opposite directions differ only in bit 1 with this encoding.
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return ((a ^ b) == 2'd2);
   endfunction

endpackage

// File: rtl/snake_core_multi_if.sv
// Control/status bundle between the input/tick side and the snake engine.
interface snake_core_multi_if #(parameter int MAX_LEN = 33);
   logic                    start;
   logic                    tick;
   logic [1:0]              dir_in;
   logic                    dir_valid;
   logic                    eat_evt;
   logic                    wrap_mode;
   logic [1:0]              state;
   logic [9:0]              head_x;
   logic [8:0]              head_y;
   logic [7:0]              length;
   logic                    move_evt;
   logic                    self_hit;
   logic                    wall_hit;
   logic [MAX_LEN*10-1:0]   body_bus_x;
   logic [MAX_LEN*9-1:0]    body_bus_y;
   logic [MAX_LEN-1:0]      body_valid;

   modport master (
      output start, tick, dir_in, dir_valid, eat_evt, wrap_mode,
      input  state, head_x, head_y, length, move_evt, self_hit, wall_hit,
             body_bus_x, body_bus_y, body_valid
   );

   modport slave (
      input  start, tick, dir_in, dir_valid, eat_evt, wrap_mode,
      output state, head_x, head_y, length, move_evt, self_hit, wall_hit,
             body_bus_x, body_bus_y, body_valid
   );
endinterface

// File: rtl/snake_dir_queue.sv
// Turn FIFO: filters duplicate and reversing requests against the most
// recently queued direction (or the current one when empty).
module snake_dir_queue
   import snake_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk_pix,
   input  logic       reset,
   input  logic       flush_i,
   input  logic       push_i,
   input  logic [1:0] dir_in_i,
   input  logic       pop_i,
   input  logic [1:0] cur_dir_i,
   output logic [1:0] dir_out_o,
   output logic       empty_o
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [1:0]    q_q [DEPTH];
   logic [1:0]    q_d [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_pop_s;
   logic [1:0]    ref_s;
   logic          pop_s;
   logic          accept_s;

   // Next-state: pop first, then filter and append the new request.
   always_comb begin
      ref_s = cur_dir_i;
      for (int i = 0; i < DEPTH; i++) begin
         ref_s = (cnt_q == CW'(i + 1)) ? q_q[i] : ref_s;
      end
      pop_s     = pop_i && (cnt_q != '0);
      cnt_pop_s = pop_s ? (cnt_q - CW'(1)) : cnt_q;
      q_d       = q_q;
      for (int i = 0; i < DEPTH - 1; i++) begin
         q_d[i] = pop_s ? q_q[i + 1] : q_q[i];
      end
      accept_s = push_i && (cnt_pop_s < CW'(DEPTH)) && (dir_in_i != ref_s)
                 && !is_reverse(dir_in_i, ref_s);
      for (int i = 0; i < DEPTH; i++) begin
         q_d[i] = (accept_s && (cnt_pop_s == CW'(i))) ? dir_in_i : q_d[i];
      end
      cnt_d = flush_i ? '0 : (accept_s ? (cnt_pop_s + CW'(1)) : cnt_pop_s);
   end

   // Queue storage and occupancy.
   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_q[i] <= DIR_RIGHT;
         end
      end else begin
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   assign dir_out_o = q_q[0];
   assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/snake_core_multi.sv
// Snake engine: game-state FSM, move/collision evaluation, growth and the
// segment array exported as packed buses.
module snake_core_multi
   import snake_pkg::*;
#(
   parameter int CELL       = 10,
   parameter int GRID_W     = 64,
   parameter int GRID_H     = 48,
   parameter int MAX_LEN    = 33,
   parameter int INIT_LEN   = 2,
   parameter int GROW_STEP  = 2,
   parameter int DIRQ_DEPTH = 2,
   parameter int START_X    = 370,
   parameter int START_Y    = 280
) (
   input  logic               clk_pix,
   input  logic               reset,
   snake_core_multi_if.slave  bus
);

   localparam logic [9:0] XMIN_C   = 10'(CELL);
   localparam logic [9:0] XMAX_C   = 10'((GRID_W - 2) * CELL);
   localparam logic [8:0] YMIN_C   = 9'(CELL);
   localparam logic [8:0] YMAX_C   = 9'((GRID_H - 2) * CELL);
   localparam logic [9:0] CELL_X   = 10'(CELL);
   localparam logic [8:0] CELL_Y   = 9'(CELL);
   localparam logic [7:0] MAXL_C   = 8'(MAX_LEN);
   localparam logic [8:0] MAXP_C   = 9'(MAX_LEN);
   localparam logic [8:0] GROW_C   = 9'(GROW_STEP);
   localparam logic [7:0] INITL_C  = 8'(INIT_LEN);

   state_e             state_q, state_d;
   logic               wrap_q, wrap_d;
   logic [1:0]         cur_dir_q, cur_dir_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         pend_q, pend_d;
   logic [9:0]         seg_x_q [MAX_LEN];
   logic [9:0]         seg_x_d [MAX_LEN];
   logic [8:0]         seg_y_q [MAX_LEN];
   logic [8:0]         seg_y_d [MAX_LEN];
   logic               move_q, move_d;
   logic               self_q, self_d;
   logic               wall_q, wall_d;
   logic [MAX_LEN-1:0] valid_q, valid_d;

   logic [1:0]         q_head_s;
   logic               q_empty_s;
   logic [1:0]         dir_eff_s;
   logic [9:0]         nx_s;
   logic [8:0]         ny_s;
   logic               out_s;
   logic               grow_s;
   logic               grew_s;
   logic               hit_s;
   logic [7:0]         lim_s;
   logic [8:0]         pend_sum_s;
   logic [MAX_LEN*10-1:0] bus_x_s;
   logic [MAX_LEN*9-1:0]  bus_y_s;

   function automatic logic [9:0] init_x(input int i);
      int k;
      k = (i < INIT_LEN) ? i : (INIT_LEN - 1);
      return 10'(START_X - k * CELL);
   endfunction

   snake_dir_queue #(.DEPTH(DIRQ_DEPTH)) u_dirq (
      .clk_pix   (clk_pix),
      .reset     (reset),
      .flush_i   ((state_q == ST_DEAD) && bus.start),
      .push_i    ((state_q == ST_RUN) && bus.dir_valid),
      .dir_in_i  (bus.dir_in),
      .pop_i     ((state_q == ST_RUN) && bus.tick),
      .cur_dir_i (cur_dir_q),
      .dir_out_o (q_head_s),
      .empty_o   (q_empty_s)
   );

   // Next-state for the whole engine: move target, collisions, FSM, growth.
   always_comb begin
      state_d    = state_q;
      wrap_d     = wrap_q;
      cur_dir_d  = cur_dir_q;
      len_d      = len_q;
      pend_d     = pend_q;
      seg_x_d    = seg_x_q;
      seg_y_d    = seg_y_q;
      move_d     = 1'b0;
      self_d     = 1'b0;
      wall_d     = 1'b0;
      grew_s     = 1'b0;
      pend_sum_s = {1'b0, pend_q};
      dir_eff_s  = q_empty_s ? cur_dir_q : q_head_s;
      nx_s       = seg_x_q[0];
      ny_s       = seg_y_q[0];
      out_s      = 1'b0;

      case (dir_eff_s)
         DIR_UP: begin
            out_s = (seg_y_q[0] < (YMIN_C + CELL_Y));
            ny_s  = out_s ? YMAX_C : (seg_y_q[0] - CELL_Y);
         end
         DIR_DOWN: begin
            out_s = (seg_y_q[0] > (YMAX_C - CELL_Y));
            ny_s  = out_s ? YMIN_C : (seg_y_q[0] + CELL_Y);
         end
         DIR_LEFT: begin
            out_s = (seg_x_q[0] < (XMIN_C + CELL_X));
            nx_s  = out_s ? XMAX_C : (seg_x_q[0] - CELL_X);
         end
         default: begin
            out_s = (seg_x_q[0] > (XMAX_C - CELL_X));
            nx_s  = out_s ? XMIN_C : (seg_x_q[0] + CELL_X);
         end
      endcase

      // The tail cell is vacated unless this move grows the body.
      grow_s = (pend_q != 8'd0) && (len_q < MAXL_C);
      lim_s  = grow_s ? len_q : (len_q - 8'd1);
      hit_s  = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         hit_s = hit_s | ((8'(i) < lim_s) && (seg_x_q[i] == nx_s) && (seg_y_q[i] == ny_s));
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               wrap_d  = bus.wrap_mode;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.tick) begin
               cur_dir_d = dir_eff_s;
               if (out_s && !wrap_q) begin
                  wall_d  = 1'b1;
                  state_d = ST_DEAD;
               end else if (hit_s) begin
                  self_d  = 1'b1;
                  state_d = ST_DEAD;
               end else begin
                  for (int i = 1; i < MAX_LEN; i++) begin
                     seg_x_d[i] = seg_x_q[i-1];
                     seg_y_d[i] = seg_y_q[i-1];
                  end
                  seg_x_d[0] = nx_s;
                  seg_y_d[0] = ny_s;
                  move_d     = 1'b1;
                  grew_s     = grow_s;
                  len_d      = grow_s ? (len_q + 8'd1) : len_q;
               end
            end else begin
               cur_dir_d = cur_dir_q;
            end
            pend_sum_s = {1'b0, pend_q} - {8'd0, grew_s} + (bus.eat_evt ? GROW_C : 9'd0);
            pend_d     = (len_d == MAXL_C) ? 8'd0 :
                         ((pend_sum_s > MAXP_C) ? MAXL_C : pend_sum_s[7:0]);
         end
         ST_DEAD: begin
            if (bus.start) begin
               state_d   = ST_RUN;
               wrap_d    = bus.wrap_mode;
               cur_dir_d = DIR_RIGHT;
               len_d     = INITL_C;
               pend_d    = 8'd0;
               for (int i = 0; i < MAX_LEN; i++) begin
                  seg_x_d[i] = init_x(i);
                  seg_y_d[i] = 9'(START_Y);
               end
            end else begin
               state_d = ST_DEAD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      for (int i = 0; i < MAX_LEN; i++) begin
         valid_d[MAX_LEN-1-i] = (8'(i) < len_d);
      end
   end

   // Engine state and registered outputs.
   always_ff @(posedge clk_pix or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         wrap_q    <= 1'b0;
         cur_dir_q <= DIR_RIGHT;
         len_q     <= INITL_C;
         pend_q    <= 8'd0;
         move_q    <= 1'b0;
         self_q    <= 1'b0;
         wall_q    <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_q[i]           <= init_x(i);
            seg_y_q[i]           <= 9'(START_Y);
            valid_q[MAX_LEN-1-i] <= (i < INIT_LEN);
         end
      end else begin
         state_q   <= state_d;
         wrap_q    <= wrap_d;
         cur_dir_q <= cur_dir_d;
         len_q     <= len_d;
         pend_q    <= pend_d;
         move_q    <= move_d;
         self_q    <= self_d;
         wall_q    <= wall_d;
         seg_x_q   <= seg_x_d;
         seg_y_q   <= seg_y_d;
         valid_q   <= valid_d;
      end
   end

   // Pack segments with the head in the most significant slot.
   always_comb begin
      bus_x_s = '0;
      bus_y_s = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         bus_x_s[(MAX_LEN-1-i)*10 +: 10] = seg_x_q[i];
         bus_y_s[(MAX_LEN-1-i)*9 +: 9]   = seg_y_q[i];
      end
   end

   assign bus.state      = state_q;
   assign bus.head_x     = seg_x_q[0];
   assign bus.head_y     = seg_y_q[0];
   assign bus.length     = len_q;
   assign bus.move_evt   = move_q;
   assign bus.self_hit   = self_q;
   assign bus.wall_hit   = wall_q;
   assign bus.body_bus_x = bus_x_s;
   assign bus.body_bus_y = bus_y_s;
   assign bus.body_valid = valid_q;

endmodule

// File: tb/tb_snake_core_multi.sv
// Bench for snake_core_multi: directed scenarios plus random play, every
// cycle compared against a queue-based model of the game rules.
module tb_snake_core_multi;

   localparam int CELL = 10, GRID_W = 64, GRID_H = 48, MAX_LEN = 33, INIT_LEN = 2;
   localparam int GROW_STEP = 2, DIRQ_DEPTH = 2, START_X = 370, START_Y = 280;
   localparam int XMIN = CELL, XMAX = (GRID_W - 2) * CELL;
   localparam int YMIN = CELL, YMAX = (GRID_H - 2) * CELL;

   logic clk_pix = 1'b0;
   logic reset;

   snake_core_multi_if #(.MAX_LEN(MAX_LEN)) bus ();

   snake_core_multi #(
      .CELL(CELL), .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN),
      .INIT_LEN(INIT_LEN), .GROW_STEP(GROW_STEP), .DIRQ_DEPTH(DIRQ_DEPTH),
      .START_X(START_X), .START_Y(START_Y)
   ) dut (
      .clk_pix (clk_pix),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_pix = ~clk_pix;

   int err_cnt = 0;
   int chk_cnt = 0;
   int move_total = 0;

   int m_state, m_len, m_pend, m_dir, m_wrap, m_move, m_self, m_wall;
   int dq[$];
   int sx[$];
   int sy[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      int k;
      m_state = 0; m_len = INIT_LEN; m_pend = 0; m_dir = 3; m_wrap = 0;
      m_move = 0; m_self = 0; m_wall = 0;
      dq.delete(); sx.delete(); sy.delete();
      for (int i = 0; i < MAX_LEN; i++) begin
         k = (i < INIT_LEN) ? i : INIT_LEN - 1;
         sx.push_back(START_X - k * CELL);
         sy.push_back(START_Y);
      end
   endtask

   task automatic model_step(input bit st, input bit tk, input int d, input bit dv,
                             input bit eat, input bit wr);
      int ref_dir, nx, ny, lim;
      bit wall, hit, grow;
      m_move = 0; m_self = 0; m_wall = 0;
      if (m_state == 0) begin
         if (st) begin m_wrap = wr; m_state = 1; end
      end else if (m_state == 2) begin
         if (st) begin model_init(); m_wrap = wr; m_state = 1; end
      end else begin
         ref_dir = (dq.size() > 0) ? dq[$] : m_dir;
         if (tk) begin
            if (dq.size() > 0) m_dir = dq.pop_front();
            nx = sx[0]; ny = sy[0];
            case (m_dir)
               0: ny -= CELL;
               1: nx -= CELL;
               2: ny += CELL;
               default: nx += CELL;
            endcase
            wall = 0;
            if (nx < XMIN || nx > XMAX) begin
               if (m_wrap != 0) nx = (nx < XMIN) ? XMAX : XMIN; else wall = 1;
            end
            if (ny < YMIN || ny > YMAX) begin
               if (m_wrap != 0) ny = (ny < YMIN) ? YMAX : YMIN; else wall = 1;
            end
            grow = (m_pend > 0) && (m_len < MAX_LEN);
            lim  = grow ? m_len - 1 : m_len - 2;
            hit  = 0;
            for (int i = 1; i <= lim; i++)
               if (sx[i] == nx && sy[i] == ny) hit = 1;
            if (wall) begin
               m_wall = 1; m_state = 2;
            end else if (hit) begin
               m_self = 1; m_state = 2;
            end else begin
               sx.push_front(nx); sy.push_front(ny);
               void'(sx.pop_back()); void'(sy.pop_back());
               m_move = 1;
               if (grow) begin m_len++; m_pend--; end
            end
         end
         if (dv && dq.size() < DIRQ_DEPTH && d != ref_dir && d != (ref_dir ^ 2))
            dq.push_back(d);
         if (eat) m_pend = (m_pend + GROW_STEP > MAX_LEN) ? MAX_LEN : m_pend + GROW_STEP;
         if (m_len == MAX_LEN) m_pend = 0;
      end
   endtask

   function automatic logic [9:0] dut_seg_x(input int i);
      return bus.body_bus_x[(MAX_LEN-1-i)*10 +: 10];
   endfunction

   function automatic logic [8:0] dut_seg_y(input int i);
      return bus.body_bus_y[(MAX_LEN-1-i)*9 +: 9];
   endfunction

   task automatic compare_all(input string tag);
      logic [63:0] bv;
      bv = '0;
      for (int i = 0; i < m_len; i++) bv[MAX_LEN-1-i] = 1'b1;
      check_val({tag, ".state"}, 64'(bus.state), 64'(m_state));
      check_val({tag, ".length"}, 64'(bus.length), 64'(m_len));
      check_val({tag, ".move"}, 64'(bus.move_evt), 64'(m_move));
      check_val({tag, ".self"}, 64'(bus.self_hit), 64'(m_self));
      check_val({tag, ".wall"}, 64'(bus.wall_hit), 64'(m_wall));
      check_val({tag, ".valid"}, 64'(bus.body_valid), bv);
      check_val({tag, ".head_x"}, 64'(bus.head_x), 64'(sx[0]));
      check_val({tag, ".head_y"}, 64'(bus.head_y), 64'(sy[0]));
      for (int i = 0; i < m_len; i++) begin
         check_val($sformatf("%s.segx%0d", tag, i), 64'(dut_seg_x(i)), 64'(sx[i]));
         check_val($sformatf("%s.segy%0d", tag, i), 64'(dut_seg_y(i)), 64'(sy[i]));
      end
   endtask

   task automatic clear_inputs();
      bus.start = 1'b0; bus.tick = 1'b0; bus.dir_in = 2'd0;
      bus.dir_valid = 1'b0; bus.eat_evt = 1'b0; bus.wrap_mode = 1'b0;
   endtask

   task automatic cyc(input bit st, input bit tk, input int d, input bit dv,
                      input bit eat, input bit wr);
      bus.start = st; bus.tick = tk; bus.dir_in = 2'(d);
      bus.dir_valid = dv; bus.eat_evt = eat; bus.wrap_mode = wr;
      model_step(st, tk, d, dv, eat, wr);
      @(posedge clk_pix); #1;
      if (bus.move_evt === 1'b1) move_total++;
      compare_all("cyc");
      clear_inputs();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic turn(input int d);
      cyc(1'b0, 1'b0, d, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic eat();
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic go(input bit wr);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, wr);
   endtask

   // Reset is raised between clock edges so the async clear is observed.
   task automatic do_reset();
      @(posedge clk_pix); #1;
      reset = 1'b1;
      clear_inputs();
      #2;
      model_init();
      compare_all("rst");
      @(posedge clk_pix); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      #12;

      do_reset();
      check_val("init_len", 64'(bus.length), 64'd2);
      check_val("init_hx", 64'(bus.head_x), 64'd370);
      check_val("init_state", 64'(bus.state), 64'd0);
      check_val("init_valid", 64'(bus.body_valid), 64'h1_8000_0000);
      tick_n(1);
      check_val("idle_tick_hx", 64'(bus.head_x), 64'd370);
      go(1'b0);
      move_total = 0;
      tick_n(3);
      check_val("t3_hx", 64'(bus.head_x), 64'd400);
      check_val("t3_hy", 64'(bus.head_y), 64'd280);
      check_val("t3_seg1x", 64'(dut_seg_x(1)), 64'd390);
      check_val("t3_len", 64'(bus.length), 64'd2);
      check_val("t3_moves", 64'(move_total), 64'd3);
      eat();
      tick_n(1);
      check_val("grow_len3", 64'(bus.length), 64'd3);
      tick_n(1);
      check_val("grow_len4", 64'(bus.length), 64'd4);
      check_val("grow_seg3x", 64'(dut_seg_x(3)), 64'd390);
      check_val("grow_valid", 64'(bus.body_valid), 64'h1_E000_0000);

      do_reset();
      go(1'b0);
      turn(1); turn(0); turn(1);
      tick_n(1);
      check_val("turn1_hx", 64'(bus.head_x), 64'd370);
      check_val("turn1_hy", 64'(bus.head_y), 64'd270);
      tick_n(1);
      check_val("turn2_hx", 64'(bus.head_x), 64'd360);

      do_reset();
      go(1'b0);
      tick_n(25);
      check_val("edge_hx", 64'(bus.head_x), 64'd620);
      tick_n(1);
      check_val("wall_pulse", 64'(bus.wall_hit), 64'd1);
      check_val("wall_state", 64'(bus.state), 64'd2);
      check_val("wall_hx", 64'(bus.head_x), 64'd620);
      tick_n(1);
      check_val("wall_pulse_end", 64'(bus.wall_hit), 64'd0);
      go(1'b1);
      check_val("restart_state", 64'(bus.state), 64'd1);
      check_val("restart_len", 64'(bus.length), 64'd2);
      tick_n(26);
      check_val("wrap_hx", 64'(bus.head_x), 64'd10);

      do_reset();
      go(1'b0);
      eat(); tick_n(2); eat(); tick_n(1);
      turn(0); tick_n(1); turn(1); tick_n(1); turn(2); tick_n(1);
      check_val("self_pulse", 64'(bus.self_hit), 64'd1);
      check_val("self_state", 64'(bus.state), 64'd2);
      check_val("self_hy", 64'(bus.head_y), 64'd270);

      do_reset();
      go(1'b0);
      eat(); tick_n(2);
      turn(0); tick_n(1); turn(1); tick_n(1); turn(2); tick_n(1);
      check_val("tail_move", 64'(bus.move_evt), 64'd1);
      check_val("tail_state", 64'(bus.state), 64'd1);
      check_val("tail_hy", 64'(bus.head_y), 64'd280);

      do_reset();
      go(1'b1);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      tick_n(30);
      check_val("max_len", 64'(bus.length), 64'd33);
      eat(); tick_n(5);
      check_val("max_hold", 64'(bus.length), 64'd33);
      do_reset();
      check_val("midrst_len", 64'(bus.length), 64'd2);
      check_val("midrst_hx", 64'(bus.head_x), 64'd370);
      check_val("midrst_state", 64'(bus.state), 64'd0);

      for (int run = 0; run < 6; run++) begin
         do_reset();
         go(1'($urandom_range(0, 1)));
         for (int c = 0; c < 250; c++) begin
            cyc(1'((m_state == 2) && ($urandom_range(0, 5) == 0)),
                1'($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 1)));
         end
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
